// File: rtl/rvx_uart_arb_pkg.sv
// Shared definitions for the UART TX byte-stream arbiter: FSM state
// encoding, requester limit and a constant width helper.
package rvx_uart_arb_pkg;

    // FSM state encoding: IDLE waits for a request, LOCKED owns the UART.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Largest requester count the arbiter is built for.
    localparam int unsigned RVX_UART_ARB_MAX_REQ = 8;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rvx_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// at or after ptr_i, wrapping modulo NUM_REQ.
import rvx_uart_arb_pkg::*;

module rvx_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        any_o    = 1'b0;
        sum      = '0;
        slot     = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            slot = sum[IDX_W-1:0];
            if (!any_o && req_i[slot]) begin
                any_o          = 1'b1;
                onehot_o[slot] = 1'b1;
                index_o        = slot;
            end
        end
    end

endmodule

// File: rtl/rvx_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte interface among NUM_REQ
// byte-stream requesters. A grant is held for a whole message (until the
// byte flagged req_last is accepted). Every release is followed by one
// IDLE bubble cycle before the next grant.
// Optional build macro RVX_UART_ARB_TIMEOUT_EN adds a forced release after
// TIMEOUT_CYCLES consecutive idle cycles of the granted requester.
// Handshake: a byte moves when valid and ready are both high on a rising
// clock edge; valid must not depend on ready, and data holds until accepted.
import rvx_uart_arb_pkg::*;

module rvx_uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant_onehot,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > RVX_UART_ARB_MAX_REQ) begin : g_bad_num_req
        $error("rvx_uart_tx_arbiter: NUM_REQ out of range");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rvx_uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               locked;
    logic               g_valid;
    logic               g_last;
    logic               msg_done;
    logic               tmo_fire;
    logic               release_grant;
    logic [IDX_W-1:0]   ptr_after_g;
    logic [7:0]         data_sel;

    rvx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .index_o  (pick_idx),
        .any_o    (pick_any)
    );

    assign locked        = (state_q == ST_LOCKED);
    assign g_valid       = req_valid[gidx_q];
    assign g_last        = req_last[gidx_q];
    assign msg_done      = locked & g_valid & tx_ready & g_last;
    assign release_grant = msg_done | tmo_fire;
    assign ptr_after_g   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Byte mux from the granted requester.
    always_comb begin
        data_sel = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gidx_q == IDX_W'(i)) begin
                data_sel = req_data[8*i +: 8];
            end
        end
    end

`ifdef RVX_UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Idle-while-granted counter; a valid byte (even a stalled one) clears it.
    always_comb begin
        if (!locked || g_valid || tmo_fire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tmo_fire = locked & ~g_valid & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Grant FSM: arbitrate in IDLE, hold the owner until release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                end
            end
            ST_LOCKED: begin
                if (release_grant) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after_g;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FSM and arbitration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign tx_valid     = locked & g_valid;
    assign tx_data      = locked ? data_sel : 8'h00;
    assign req_ready    = locked ? (grant_q & {NUM_REQ{tx_ready}}) : '0;
    assign grant_onehot = grant_q;
    assign busy         = locked;
    assign timeout      = tmo_fire;

endmodule
